// File: rtl/fm_phase_discriminator_if.sv
// AXI-Stream style bundle used on both sides of the FM phase discriminator.
// Master drives payload and valid; slave drives ready.
interface fm_phase_discriminator_if #(
  parameter int DATA_W = 32
) ();
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    output tstrb,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    input  tstrb,
    output tready
  );
endinterface

// File: rtl/fm_phase_discriminator.sv
// FM demodulator back end: wrapped phase difference of CORDIC samples, squelched,
// averaged over C_DECIM inputs and emitted as signed 16-bit audio on AXI-Stream.
module fm_phase_discriminator #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_DECIM                = 8,
  parameter int C_MAG_THRESHOLD        = 64
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  fm_phase_discriminator_if.slave         s00_axis,
  fm_phase_discriminator_if.master        m00_axis
);

  localparam int SHIFT = $clog2(C_DECIM);
  localparam int ACC_W = 16 + SHIFT;
  localparam int CNT_W = (SHIFT > 0) ? SHIFT : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_DECIM - 1);
  localparam logic [15:0]      MAG_THR  = 16'(C_MAG_THRESHOLD);

  if (C_S00_AXIS_TDATA_WIDTH != 32) begin : g_bad_s_width
    $fatal(1, "fm_phase_discriminator: C_S00_AXIS_TDATA_WIDTH must be 32");
  end
  if (C_M00_AXIS_TDATA_WIDTH != 32) begin : g_bad_m_width
    $fatal(1, "fm_phase_discriminator: C_M00_AXIS_TDATA_WIDTH must be 32");
  end
  if (C_DECIM < 1 || C_DECIM > 256 || (C_DECIM & (C_DECIM - 1)) != 0) begin : g_bad_decim
    $fatal(1, "fm_phase_discriminator: C_DECIM must be a power of two in 1..256");
  end
  if (C_MAG_THRESHOLD < 0 || C_MAG_THRESHOLD > 65535) begin : g_bad_thr
    $fatal(1, "fm_phase_discriminator: C_MAG_THRESHOLD must fit in 16 bits");
  end

  logic [15:0]             prev_phase_q, prev_phase_d;
  logic                    have_prev_q, have_prev_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [31:0]             out_data_q, out_data_d;

  logic                    s_ready;
  logic                    accept;
  logic                    emit;
  logic [15:0]             phase;
  logic [15:0]             mag;
  logic signed [15:0]      delta;
  logic signed [ACC_W-1:0] acc_next;
  logic [15:0]             out_sample;
  logic                    unused_tstrb;

  assign unused_tstrb = ^s00_axis.tstrb;

  // Input is only taken when the output register is free or draining this cycle,
  // so a stalled output freezes all accumulation state.
  assign s_ready         = !out_valid_q || m00_axis.tready;
  assign s00_axis.tready = s_ready;
  assign accept          = s00_axis.tvalid && s_ready;

  assign phase = s00_axis.tdata[31:16];
  assign mag   = s00_axis.tdata[15:0];

  // Modular 16-bit subtraction gives the shortest signed angle step directly.
  always_comb begin
    delta = '0;
    if (have_prev_q && (mag >= MAG_THR)) begin
      delta = $signed(phase - prev_phase_q);
    end
  end

  assign acc_next   = acc_q + ACC_W'(delta);
  assign emit       = accept && ((count_q == CNT_LAST) || s00_axis.tlast);
  assign out_sample = 16'(acc_next >>> SHIFT);

  always_comb begin
    prev_phase_d = prev_phase_q;
    have_prev_d  = have_prev_q;
    acc_d        = acc_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;

    if (out_valid_q && m00_axis.tready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      prev_phase_d = phase;
      have_prev_d  = !s00_axis.tlast;
      if (emit) begin
        // Partial bursts use the same shift, i.e. missing samples count as zero.
        acc_d       = '0;
        count_d     = '0;
        out_valid_d = 1'b1;
        out_last_d  = s00_axis.tlast;
        out_data_d  = {{16{out_sample[15]}}, out_sample};
      end else begin
        acc_d   = acc_next;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      prev_phase_q <= '0;
      have_prev_q  <= 1'b0;
      acc_q        <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      prev_phase_q <= prev_phase_d;
      have_prev_q  <= have_prev_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
    end
  end

  assign m00_axis.tvalid = out_valid_q;
  assign m00_axis.tlast  = out_last_q;
  assign m00_axis.tdata  = out_data_q;
  assign m00_axis.tstrb  = 4'hf;

endmodule

// File: tb/tb_fm_phase_discriminator.sv
// Directed and randomized bench for fm_phase_discriminator (C_DECIM=4, threshold 64)
// with an arithmetic reference model of the demodulated audio stream.
module tb_fm_phase_discriminator;

  localparam int DECIM = 4;
  localparam int THR   = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rand_bp = 1'b0;

  always #5 clk = ~clk;

  fm_phase_discriminator_if s_if ();
  fm_phase_discriminator_if m_if ();

  fm_phase_discriminator #(
    .C_S00_AXIS_TDATA_WIDTH (32),
    .C_M00_AXIS_TDATA_WIDTH (32),
    .C_DECIM                (DECIM),
    .C_MAG_THRESHOLD        (THR)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis         (s_if),
    .m00_axis         (m_if)
  );

  int checks = 0;
  int errors = 0;

  int          m_prev;
  bit          m_have;
  int          m_sum;
  int          m_n;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic [32:0] mon_got;

  function automatic int floor_div(input int num, input int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  function automatic void model_reset();
    m_prev = 0;
    m_have = 1'b0;
    m_sum  = 0;
    m_n    = 0;
    exp_q.delete();
  endfunction

  // Audio = mean of the shortest-angle phase steps over a block, rounded toward -inf.
  function automatic void model_accept(input logic [15:0] ph, input logic [15:0] mg,
                                       input logic last);
    int d;
    d = 0;
    if (m_have && int'(mg) >= THR) begin
      d = int'(ph) - m_prev;
      if (d > 32767) d -= 65536;
      else if (d < -32768) d += 65536;
    end
    m_sum += d;
    m_n++;
    if (m_n == DECIM || last) begin
      exp_q.push_back({last, 32'(floor_div(m_sum, DECIM))});
      m_sum = 0;
      m_n   = 0;
    end
    m_prev = int'(ph);
    m_have = !last;
  endfunction

  task automatic check_output(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.tvalid && m_if.tready) begin
        mon_got = {m_if.tlast, m_if.tdata};
        obs_q.push_back(mon_got);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL unexpected_output observed=%h expected=none", mon_got);
        end else begin
          check_output("stream_out", mon_got, exp_q.pop_front());
        end
      end
      if (s_if.tvalid && s_if.tready) begin
        model_accept(s_if.tdata[31:16], s_if.tdata[15:0], s_if.tlast);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      m_if.tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the sample has been accepted.
  task automatic apply_stimulus(input logic [15:0] ph, input logic [15:0] mg, input logic last);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {ph, mg};
    s_if.tlast  = last;
    while (!done) begin
      @(negedge clk);
      if (s_if.tready) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $error("[TB] FAIL accept_timeout observed=%0d cycles required<=200", waited);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_if.tvalid) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 100) begin
          checks++;
          errors++;
          $error("[TB] FAIL drain_timeout observed=%0d pending required=0", exp_q.size());
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string tag, input logic [32:0] exp);
    logic [32:0] got;
    got = 'x;
    if (obs_q.size() != 0) got = obs_q.pop_front();
    check_output(tag, got, exp);
  endtask

  task automatic ramp(input int start, input int step, input int n, input logic [15:0] mg);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(16'(start + i * step), mg, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] rph;
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rph;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    s_if.tstrb  = 4'h0;
    m_if.tready = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_tvalid", 33'(m_if.tvalid), 33'd0);
    check_output("reset_tlast",  33'(m_if.tlast),  33'd0);
    check_output("reset_tdata",  33'(m_if.tdata),  33'd0);
    check_output("tstrb_const",  33'(m_if.tstrb),  33'hf);
    check_output("reset_sready", 33'(s_if.tready), 33'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp
    obs_q.delete();
    ramp(0, 100, 8, 16'd1000);
    wait_drain();
    check_output("ramp_count", 33'(obs_q.size()), 33'd2);
    check_obs("ramp_out0", {1'b0, 32'd75});
    check_obs("ramp_out1", {1'b0, 32'd100});

    // Wrap-around in both directions after priming the history at 0x7700
    obs_q.delete();
    apply_stimulus(16'h7700, 16'd1000, 1'b1);
    ramp(16'h7700, 0, 4, 16'd1000);
    ramp(16'h7D00, 16'h0600, 4, 16'd1000);
    ramp(16'h8900, -16'sh0600, 4, 16'd1000);
    wait_drain();
    check_obs("flush_prime", {1'b1, 32'd7441});
    check_obs("prime_zero",  {1'b0, 32'd0});
    check_obs("wrap_up",     {1'b0, 32'd1536});
    check_obs("wrap_down",   {1'b0, 32'hFFFFFA00});

    // Squelch: below, at and just under the threshold
    obs_q.delete();
    ramp(0, 100, 4, 16'd10);
    ramp(400, 100, 4, 16'd64);
    ramp(800, 100, 4, 16'd63);
    wait_drain();
    check_obs("squelch_low", {1'b0, 32'd0});
    check_obs("squelch_eq",  {1'b0, 32'd100});
    check_obs("squelch_63",  {1'b0, 32'd0});

    // Early tlast flushes a partial average and clears the phase history
    obs_q.delete();
    apply_stimulus(16'd1100, 16'd1000, 1'b1);
    apply_stimulus(16'd0, 16'd1000, 1'b0);
    apply_stimulus(16'd100, 16'd1000, 1'b1);
    ramp(50, 100, 4, 16'd1000);
    wait_drain();
    check_obs("tlast_flush0", {1'b1, 32'd0});
    check_obs("tlast_partial", {1'b1, 32'd25});
    check_obs("after_tlast",  {1'b0, 32'd75});

    // Backpressure holds the output and stops input acceptance
    obs_q.delete();
    m_if.tready = 1'b0;
    ramp(450, 100, 4, 16'd1000);
    s_if.tvalid = 1'b1;
    s_if.tdata  = {16'd850, 16'd1000};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("bp_sready", 33'(s_if.tready), 33'd0);
      check_output("bp_tvalid", 33'(m_if.tvalid), 33'd1);
      check_output("bp_hold",   {m_if.tlast, m_if.tdata}, {1'b0, 32'd100});
    end
    @(posedge clk);
    #1;
    m_if.tready = 1'b1;
    apply_stimulus(16'd850, 16'd1000, 1'b0);
    ramp(950, 100, 3, 16'd1000);
    wait_drain();
    check_output("bp_count", 33'(obs_q.size()), 33'd2);
    check_obs("bp_out0", {1'b0, 32'd100});
    check_obs("bp_out1", {1'b0, 32'd100});

    // Reset with a stalled output, then with a partial sum
    obs_q.delete();
    m_if.tready = 1'b0;
    ramp(0, 100, 4, 16'd1000);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("rst_tvalid_drop", 33'(m_if.tvalid), 33'd0);
    check_output("rst_tdata_clear", 33'(m_if.tdata),  33'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    @(posedge clk);
    #1;
    ramp(0, 100, 2, 16'd1000);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs_q.delete();
    ramp(0, 100, 4, 16'd1000);
    wait_drain();
    check_output("rst_count", 33'(obs_q.size()), 33'd1);
    check_obs("rst_ramp", {1'b0, 32'd75});

    // Randomized traffic with random downstream stalls
    rand_bp = 1'b1;
    rph = 16'($urandom);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) rph = 16'($urandom);
      else rph = rph + 16'($urandom_range(0, 4000)) - 16'd2000;
      apply_stimulus(rph, 16'($urandom_range(0, 130)), ($urandom_range(0, 19) == 0));
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    m_if.tready = 1'b1;
    wait_drain();
    check_output("final_pending", 33'(exp_q.size()), 33'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_phase_discriminator.md
Name: fm_phase_discriminator

Overview:
- Consumes the CORDIC output stream: tdata[31:16] is phase (unsigned 16-bit, full circle = 65536), tdata[15:0] is magnitude.
- Computes the wrapped phase difference between consecutive samples, which is the instantaneous frequency and therefore the FM-demodulated audio.
- Squelches low-magnitude samples, then averages and decimates by C_DECIM.
- Emits one signed 16-bit audio sample per C_DECIM inputs on an AXI-Stream master, for the downstream audio path.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input stream width; must be 32.
- C_M00_AXIS_TDATA_WIDTH, 32, output stream width; must be 32.
- C_DECIM, 8, decimation/averaging factor; power of two, 1..256; checked at elaboration with $fatal.
- C_MAG_THRESHOLD, 64, squelch level; samples with mag < threshold contribute zero delta.

Ports:
- s00_axis_aclk  in  1  clock
- s00_axis_aresetn  in  1  asynchronous active-low reset
- s00_axis_tvalid  in  1  input sample valid
- s00_axis_tlast  in  1  end of burst; flushes the partial average and resets phase history
- s00_axis_tdata  in  32  [31:16] phase, [15:0] magnitude
- s00_axis_tstrb  in  4  ignored
- s00_axis_tready  out  1  input accept
- m00_axis_tready  in  1  downstream ready
- m00_axis_tvalid  out  1  output sample valid
- m00_axis_tlast  out  1  marks the flushed output of a tlast burst
- m00_axis_tdata  out  32  signed audio sample in [15:0], sign-extended into [31:16]
- m00_axis_tstrb  out  4  constant 4'hf

Behaviour:
- Reset (async assert, sync release): prev_phase=0, have_prev=0, acc=0, count=0, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0.
- Handshakes:
  - s00_axis_tready = !m00_axis_tvalid || m00_axis_tready (combinational).
  - Input accept = s00_axis_tvalid && s00_axis_tready.
  - Output transfer = m00_axis_tvalid && m00_axis_tready.
- Per accepted sample:
  - phase = tdata[31:16], mag = tdata[15:0].
  - delta = $signed(phase - prev_phase), 16-bit modular subtraction, so wrap-around is inherent: 0x8300 - 0x7D00 = +1536.
  - If have_prev==0, delta=0.
  - If mag < C_MAG_THRESHOLD, delta=0.
  - prev_phase <= phase; have_prev <= 1, or 0 if tlast.
- Accumulator: signed, width 16+log2(C_DECIM), so it never overflows. acc_next = acc + sign-extended delta.
- Emit condition: count==C_DECIM-1, or tlast on the accepted sample. When it holds, on that same edge:
  - out = acc_next >>> log2(C_DECIM), arithmetic shift (floor), truncated to 16 bits.
  - m00_axis_tdata <= {{16{out[15]}}, out}; m00_axis_tvalid <= 1; m00_axis_tlast <= input tlast.
  - acc <= 0; count <= 0.
  - A partial flush uses the same shift: it is scaled as if the missing samples were zero.
- Otherwise: acc <= acc_next, count <= count+1.
- Latency: output is valid the cycle after the edge that accepts the emitting sample.
- Output register:
  - Holds tdata/tlast stable while tvalid && !tready.
  - Clears tvalid on transfer unless a new emit happens on the same edge, in which case it reloads (back-to-back allowed when C_DECIM==1).
- Backpressure: while the output is stalled, s00_axis_tready=0 and no sample is accepted; accumulator state is frozen.
- Idle input (tvalid=0): no state change.
- C_DECIM==1: every accepted sample emits; out = delta.
- Reset mid-accumulation discards the partial sum and phase history; no output is produced for it.

Test Plan:
- Ramp, C_DECIM=4, threshold=64: phases 0,100,200,…,700 with mag=1000, no backpressure.
  -> Output 1 = (0+100+100+100)>>>2 = 75; output 2 = 100; tlast=0 on both.
- Wrap: phases 0x7D00,0x8300,0x8900,0x8F00 after a primed history at 0x7700.
  -> Output = 1536. Descending sequence -> -1536 (0xFFFFFA00 on tdata).
- Squelch: ramp as above but mag=10.
  -> Outputs 0. Mag exactly 64 -> not squelched.
- Early tlast: phases 0,100 with tlast on the second sample.
  -> One output 25, tlast=1. Next burst starts with delta=0 (have_prev cleared).
- Backpressure: hold m00_axis_tready=0 with an output pending.
  -> s00_axis_tready=0, tdata stable for 10 cycles; on release one transfer, then input resumes with no sample lost or duplicated.
- Reset: assert aresetn low after 2 of 4 samples, then feed a fresh ramp.
  -> tvalid drops immediately; the first post-reset output matches scenario 1 (75).
